// File: rtl/multi_event_counter.sv
// Multi-channel event counter: level/edge qualify, wrap/saturate,
// per-channel clear, sticky overflow and a registered overflow summary.
module multi_event_counter #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 2,
  parameter int SATURATE  = 0,
  parameter int EDGE_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       test_inc,
  output logic [NUM_CH*CNT_W-1:0] out,
  output logic [NUM_CH-1:0]       ovf,
  output logic                    any_ovf
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] evt;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;
  logic              any_q;

  // prev tracks the raw input every cycle, so gated edges are consumed
  always_comb begin
    if (EDGE_MODE != 0) evt = test_inc & ~prev;
    else                evt = test_inc;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clr[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (en && evt[i]) begin
        if (cnt_q[i] != MAX) begin
          cnt_d[i] = cnt_q[i] + ONE;
        end else begin
          cnt_d[i] = (SATURATE != 0) ? MAX : '0;
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= '0;
      ovf_q <= '0;
      any_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= '0;
    end else begin
      prev  <= test_inc;
      ovf_q <= ovf_d;
      any_q <= |ovf_q;
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < NUM_CH; i++)
      out[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign ovf     = ovf_q;
  assign any_ovf = any_q;

endmodule

// File: tb/tb_multi_event_counter.sv
// Directed bench for multi_event_counter: level/wrap, edge, saturate,
// clear/enable priority and asynchronous reset, on three configurations.
module tb_multi_event_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] clr = '0;
  logic [1:0] inc = '0;

  logic [3:0] out_l, out_e, out_s;
  logic [1:0] ovf_l, ovf_e, ovf_s;
  logic       any_l, any_e, any_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_event_counter #(
    .NUM_CH(2), .CNT_W(2), .SATURATE(0), .EDGE_MODE(0)
  ) u_lvl (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .test_inc(inc), .out(out_l), .ovf(ovf_l), .any_ovf(any_l)
  );

  multi_event_counter #(
    .NUM_CH(2), .CNT_W(2), .SATURATE(0), .EDGE_MODE(1)
  ) u_edge (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .test_inc(inc), .out(out_e), .ovf(ovf_e), .any_ovf(any_e)
  );

  multi_event_counter #(
    .NUM_CH(2), .CNT_W(2), .SATURATE(1), .EDGE_MODE(0)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .test_inc(inc), .out(out_s), .ovf(ovf_s), .any_ovf(any_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    clr = '0;
    inc = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    clr = '0;
    inc = '0;
    repeat (3) step();
    tests++;
    if ({out_l, out_e, out_s} !== 12'h000) begin
      fails++;
      $display("FAIL reset_out got %h want 000",
               {out_l, out_e, out_s});
    end
    tests++;
    if ({ovf_l, ovf_e, ovf_s, any_l, any_e, any_s} !== 9'h0) begin
      fails++;
      $display("FAIL reset_ovf got %b want 0",
               {ovf_l, ovf_e, ovf_s, any_l, any_e, any_s});
    end
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      tests++;
      if ({out_l, out_e, out_s, ovf_l, ovf_e, ovf_s,
           any_l, any_e, any_s} !== 21'h0) begin
        fails++;
        $display("FAIL idle[%0d] got %h want 0", k,
                 {out_l, out_e, out_s, ovf_l, ovf_e, ovf_s,
                  any_l, any_e, any_s});
      end
    end
  endtask

  task automatic test_level_wrap();
    logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_a [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    en = 1'b1;
    inc = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if ({out_l, ovf_l, any_l} !==
          {2'd0, exp_c[k], 1'b0, exp_o[k], exp_a[k]}) begin
        fails++;
        $display("FAIL wrap[%0d] got out=%h ovf=%b any=%b want out=%h ovf=%b any=%b",
                 k, out_l, ovf_l, any_l, {2'd0, exp_c[k]},
                 {1'b0, exp_o[k]}, exp_a[k]);
      end
    end
    inc = '0;
  endtask

  task automatic test_edge();
    do_reset();
    en = 1'b1;
    inc = 2'b10;
    repeat (4) step();
    inc = 2'b00;
    repeat (2) step();
    inc = 2'b10;
    step();
    inc = 2'b00;
    step();
    tests++;
    if (out_e !== 4'b1000) begin
      fails++;
      $display("FAIL edge_count got %h want 8", out_e);
    end
    rst_n = 1'b0;
    inc = 2'b01;
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (out_e !== 4'b0001) begin
      fails++;
      $display("FAIL edge_at_release got %h want 1", out_e);
    end
    step();
    tests++;
    if (out_e !== 4'b0001) begin
      fails++;
      $display("FAIL edge_held got %h want 1", out_e);
    end
    inc = '0;
  endtask

  task automatic test_saturate();
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      inc = 2'b01;
      step();
      inc = 2'b00;
      step();
      tests++;
      if (out_s !== ((k < 3) ? k[3:0] : 4'd3)
          || ovf_s !== ((k >= 4) ? 2'b01 : 2'b00)) begin
        fails++;
        $display("FAIL sat[%0d] got out=%h ovf=%b want out=%h ovf=%b",
                 k, out_s, ovf_s, (k < 3) ? k[3:0] : 4'd3,
                 (k >= 4) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_clear_enable();
    do_reset();
    en = 1'b1;
    inc = 2'b11;
    repeat (5) step();
    tests++;
    if (out_l !== 4'h5 || ovf_l !== 2'b11) begin
      fails++;
      $display("FAIL clr_pre got out=%h ovf=%b want out=5 ovf=11",
               out_l, ovf_l);
    end
    clr = 2'b01;
    inc = 2'b01;
    step();
    clr = 2'b00;
    inc = 2'b00;
    tests++;
    if (out_l !== 4'h4 || ovf_l !== 2'b10) begin
      fails++;
      $display("FAIL clr_prio got out=%h ovf=%b want out=4 ovf=10",
               out_l, ovf_l);
    end
    en = 1'b0;
    repeat (3) begin
      inc = 2'b10;
      step();
      inc = 2'b00;
      step();
    end
    tests++;
    if (out_l !== 4'h4) begin
      fails++;
      $display("FAIL en_off got %h want 4", out_l);
    end
    do_reset();
    en = 1'b0;
    inc = 2'b01;
    step();
    en = 1'b1;
    step();
    step();
    tests++;
    if (out_e !== 4'h0) begin
      fails++;
      $display("FAIL edge_consumed got %h want 0", out_e);
    end
    inc = 2'b00;
    step();
    inc = 2'b01;
    step();
    tests++;
    if (out_e !== 4'h1) begin
      fails++;
      $display("FAIL edge_after_en got %h want 1", out_e);
    end
    inc = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    inc = 2'b01;
    repeat (6) step();
    inc = 2'b00;
    tests++;
    if (out_l !== 4'h2 || ovf_l !== 2'b01 || any_l !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre got out=%h ovf=%b any=%b want 2 01 1",
               out_l, ovf_l, any_l);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_l !== 4'h0 || ovf_l !== 2'b00 || any_l !== 1'b0) begin
      fails++;
      $display("FAIL arst_now got out=%h ovf=%b any=%b want 0 00 0",
               out_l, ovf_l, any_l);
    end
    #2;
    rst_n = 1'b1;
    inc = 2'b01;
    step();
    inc = 2'b00;
    tests++;
    if (out_l !== 4'h1 || ovf_l !== 2'b00) begin
      fails++;
      $display("FAIL arst_resume got out=%h ovf=%b want 1 00",
               out_l, ovf_l);
    end
  endtask

  initial begin
    test_reset();
    test_level_wrap();
    test_edge();
    test_saturate();
    test_clear_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
